// File: rtl/ncl_mult3_sync_drv.sv
// ncl_mult3_sync_drv
// Connects clocked logic to the dual-rail 3x3 NCL multiplier.
// Single-rail operands arrive on a valid/ready interface. They are driven to the
// multiplier as DATA/NULL wavefronts under the Ki/Ko four-phase handshake. The
// dual-rail product is checked for completion, decoded, and returned on a
// valid/ready interface. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a, in_b are 3-bit unsigned
//   out_valid/out_ready   product handshake; out_p is the 6-bit product
//   a_rail1/0, b_rail1/0  dual-rail operand rails to the multiplier
//   ki                    request to the multiplier (1 = DATA, 0 = NULL)
//   ko, p_rail1/0         asynchronous acknowledge and product rails
//   err_illegal           sticky: a product bit was seen with both rails high
//   busy                  FSM is not in IDLE
//   err_timeout           (NCL_DRV_TIMEOUT_EN only) sticky phase watchdog flag
//
// Build option: define NCL_DRV_TIMEOUT_EN to add the per-phase watchdog
// (TIMEOUT_CYCLES) and the err_timeout port.

module ncl_mult3_sync_drv #(
  parameter int unsigned SYNC_STAGES = 2
`ifdef NCL_DRV_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_p,
  output logic [2:0] a_rail1,
  output logic [2:0] a_rail0,
  output logic [2:0] b_rail1,
  output logic [2:0] b_rail0,
  output logic       ki,
  input  logic       ko,
  input  logic [5:0] p_rail1,
  input  logic [5:0] p_rail0,
  output logic       err_illegal,
  output logic       busy
`ifdef NCL_DRV_TIMEOUT_EN
  , output logic     err_timeout
`endif
);

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    DATA,
    NULLW,
    RESULT
  } state_t;

  state_t state, state_n;

  // Synchronizers for the asynchronous multiplier outputs
  logic [SYNC_STAGES-1:0] ko_sync;
  logic [5:0]             pr1_sync [SYNC_STAGES];
  logic [5:0]             pr0_sync [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      ko_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        pr1_sync[i] <= '0;
        pr0_sync[i] <= '0;
      end
    end else begin
      ko_sync     <= {ko_sync[SYNC_STAGES-2:0], ko};
      pr1_sync[0] <= p_rail1;
      pr0_sync[0] <= p_rail0;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        pr1_sync[i] <= pr1_sync[i-1];
        pr0_sync[i] <= pr0_sync[i-1];
      end
    end
  end

  logic       ko_s;
  logic [5:0] pr1_s, pr0_s;
  logic       p_complete, p_null, p_illegal;

  assign ko_s  = ko_sync[SYNC_STAGES-1];
  assign pr1_s = pr1_sync[SYNC_STAGES-1];
  assign pr0_s = pr0_sync[SYNC_STAGES-1];

  // A bit with both rails high yields XOR=0, so it never counts as complete.
  assign p_complete = &(pr1_s ^ pr0_s);
  assign p_null     = ~|(pr1_s | pr0_s);
  assign p_illegal  = |(pr1_s & pr0_s);

  // Next values for every registered output
  logic [2:0] a_rail1_n, a_rail0_n, b_rail1_n, b_rail0_n;
  logic       ki_n, in_ready_n, out_valid_n, err_illegal_n, busy_n;
  logic [5:0] out_p_n;

`ifdef NCL_DRV_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] phase_cnt, phase_cnt_n;
  logic          err_timeout_n;
  logic          counting;
  logic          timeout_hit;
`endif

  always_comb begin
    state_n       = state;
    a_rail1_n     = a_rail1;
    a_rail0_n     = a_rail0;
    b_rail1_n     = b_rail1;
    b_rail0_n     = b_rail0;
    ki_n          = ki;
    in_ready_n    = in_ready;
    out_valid_n   = out_valid;
    out_p_n       = out_p;
    err_illegal_n = err_illegal | p_illegal;

    case (state)
      FLUSH: begin
        a_rail1_n  = '0;
        a_rail0_n  = '0;
        b_rail1_n  = '0;
        b_rail0_n  = '0;
        ki_n       = 1'b0;
        in_ready_n = 1'b0;
        if (p_null && ko_s) begin
          state_n    = IDLE;
          ki_n       = 1'b1;
          in_ready_n = 1'b1;
        end
      end
      IDLE: begin
        a_rail1_n  = '0;
        a_rail0_n  = '0;
        b_rail1_n  = '0;
        b_rail0_n  = '0;
        ki_n       = 1'b1;
        in_ready_n = 1'b1;
        if (in_valid && in_ready) begin
          a_rail1_n  = in_a;
          a_rail0_n  = ~in_a;
          b_rail1_n  = in_b;
          b_rail0_n  = ~in_b;
          in_ready_n = 1'b0;
          state_n    = DATA;
        end
      end
      DATA: begin
        ki_n = 1'b1;
        if (p_complete && !ko_s) begin
          out_p_n   = pr1_s;
          a_rail1_n = '0;
          a_rail0_n = '0;
          b_rail1_n = '0;
          b_rail0_n = '0;
          ki_n      = 1'b0;
          state_n   = NULLW;
        end
      end
      NULLW: begin
        ki_n = 1'b0;
        if (p_null && ko_s) begin
          ki_n        = 1'b1;
          out_valid_n = 1'b1;
          state_n     = RESULT;
        end
      end
      RESULT: begin
        in_ready_n = 1'b0;
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        a_rail1_n   = '0;
        a_rail0_n   = '0;
        b_rail1_n   = '0;
        b_rail0_n   = '0;
        ki_n        = 1'b0;
        in_ready_n  = 1'b0;
        out_valid_n = 1'b0;
        state_n     = FLUSH;
      end
    endcase

`ifdef NCL_DRV_TIMEOUT_EN
    // The watchdog only fires while the FSM is stuck: a phase that completes on
    // the same cycle the limit is reached takes normal progress instead.
    err_timeout_n = err_timeout;
    counting      = (state == FLUSH) || (state == DATA) || (state == NULLW);
    timeout_hit   = counting && (state_n == state) &&
                    (phase_cnt == CW'(TIMEOUT_CYCLES - 1));
    if (timeout_hit) begin
      a_rail1_n     = '0;
      a_rail0_n     = '0;
      b_rail1_n     = '0;
      b_rail0_n     = '0;
      ki_n          = 1'b0;
      in_ready_n    = 1'b0;
      out_valid_n   = 1'b0;
      err_timeout_n = 1'b1;
      state_n       = FLUSH;
    end
    if (timeout_hit || (state_n != state)) begin
      phase_cnt_n = '0;
    end else if (counting) begin
      phase_cnt_n = phase_cnt + 1'b1;
    end else begin
      phase_cnt_n = phase_cnt;
    end
`endif

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FLUSH;
      a_rail1     <= '0;
      a_rail0     <= '0;
      b_rail1     <= '0;
      b_rail0     <= '0;
      ki          <= 1'b0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_p       <= '0;
      err_illegal <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_n;
      a_rail1     <= a_rail1_n;
      a_rail0     <= a_rail0_n;
      b_rail1     <= b_rail1_n;
      b_rail0     <= b_rail0_n;
      ki          <= ki_n;
      in_ready    <= in_ready_n;
      out_valid   <= out_valid_n;
      out_p       <= out_p_n;
      err_illegal <= err_illegal_n;
      busy        <= busy_n;
    end
  end

`ifdef NCL_DRV_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      phase_cnt   <= phase_cnt_n;
      err_timeout <= err_timeout_n;
    end
  end
`endif

endmodule
